// File: rtl/down_counter.sv
// Loadable down counter with one-shot / auto-reload modes and a one-cycle
// terminal-count pulse; IDLE/RUN/DONE control with registered outputs.
module down_counter #(
  parameter int NBIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load,
  input  logic [NBIT-1:0] d,
  input  logic            set_signal,
  input  logic            reload,
  output logic [NBIT-1:0] Q,
  output logic            tc,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NBIT-1:0] ZERO = {NBIT{1'b0}};
  localparam logic [NBIT-1:0] ONE  = {{(NBIT-1){1'b0}}, 1'b1};
  localparam logic [NBIT-1:0] ALL1 = {NBIT{1'b1}};

  state_t          state_q, state_d;
  logic [NBIT-1:0] q_q, q_d;
  logic [NBIT-1:0] l_q, l_d;
  logic            tc_q, tc_d;
  logic            busy_q, busy_d;

  // State, count, reload value and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= ZERO;
      l_q     <= ZERO;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      l_q     <= l_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: load > set_signal > count > hold
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    l_d     = l_q;
    tc_d    = 1'b0;
    if (load) begin
      q_d     = d;
      l_d     = d;
      state_d = (d != ZERO) ? RUN : DONE;
    end else if (set_signal) begin
      q_d     = ALL1;
      l_d     = ALL1;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (q_q == ZERO) begin
            // Zero while running only happens in auto-reload mode; a mode
            // change to one-shot ends the run without a pulse.
            if (!reload) begin
              state_d = DONE;
            end else if (en) begin
              q_d = l_q;
            end else begin
              q_d = q_q;
            end
          end else if (en) begin
            if (q_q == ONE) begin
              q_d     = ZERO;
              tc_d    = 1'b1;
              state_d = reload ? RUN : DONE;
            end else begin
              q_d = q_q - ONE;
            end
          end else begin
            q_d = q_q;
          end
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
  end

  assign Q    = q_q;
  assign tc   = tc_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_down_counter.sv
// Table-driven directed bench for down_counter (NBIT=3) plus hand-written
// asynchronous reset sequences.
module tb_down_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [2:0] d;
  logic       set_signal;
  logic       reload;
  logic [2:0] Q;
  logic       tc;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       ld;
    logic       st;
    logic       en;
    logic       rl;
    logic [2:0] d;
    logic [2:0] q;
    logic       tc;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  down_counter #(.NBIT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .d          (d),
    .set_signal (set_signal),
    .reload     (reload),
    .Q          (Q),
    .tc         (tc),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic ld, input logic st, input logic e, input logic rl,
                     input logic [2:0] dv, input logic [2:0] eq, input logic etc,
                     input logic ebusy);
    vec_t v;
    v.ld = ld; v.st = st; v.en = e; v.rl = rl; v.d = dv;
    v.q = eq; v.tc = etc; v.busy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] eq, input logic etc,
                       input logic ebusy);
    checks++;
    if (Q !== eq || tc !== etc || busy !== ebusy) begin
      failures++;
      $display("FAIL %s: got Q=%0d tc=%b busy=%b, expected Q=%0d tc=%b busy=%b",
               name, Q, tc, busy, eq, etc, ebusy);
    end
  endtask

  task automatic step(input logic ld, input logic st, input logic e, input logic rl,
                      input logic [2:0] dv);
    @(negedge clk);
    load = ld; set_signal = st; en = e; reload = rl; d = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; d = 3'd0; set_signal = 1'b0; reload = 1'b0;

    // one-shot from 5
    add(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 3'd5, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
    // auto-reload from 2, period 3
    add(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 3'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b1);
    // set, en toggling
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd6, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd6, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd5, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 1'b0, 1'b1);
    // load zero goes straight to DONE
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0);
    // load beats set; load beats the 1->0 count
    add(1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 3'd4, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 3'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 3'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 3'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 3'd0, 1'b1, 1'b0);
    // reload register takes the load value when set is also high
    add(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 3'd4, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd4, 1'b0, 1'b1);
    // mode change to one-shot while sitting at zero
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);

    // inputs are ignored while reset is held
    #2;
    check("reset_async", 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd5);
    check("reset_held_ignores_load", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    load = 1'b0; en = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ld, vecs[i].st, vecs[i].en, vecs[i].rl, vecs[i].d);
      checks++;
      if (Q !== vecs[i].q || tc !== vecs[i].tc || busy !== vecs[i].busy) begin
        failures++;
        $display("FAIL vec%0d: got Q=%0d tc=%b busy=%b, expected Q=%0d tc=%b busy=%b",
                 i, Q, tc, busy, vecs[i].q, vecs[i].tc, vecs[i].busy);
      end
    end

    // reset mid-count aborts the run with no pulse
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd6);
    check("midrst_load6", 3'd6, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    check("midrst_at3", 3'd3, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_immediate", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("after_rst_idle", 3'd0, 1'b0, 1'b0);
    end

    // reset just before the 1->0 edge must suppress the pulse
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    check("prepulse_at1", 3'd1, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("prepulse_no_tc", 3'd0, 1'b0, 1'b0);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
